// File: rtl/cmp_bist_sequencer.sv
// cmp_bist_sequencer: built-in self-test sequencer for the equality comparator.
// Walks every (a, b) operand pair, waits SETTLE_CYC cycles, then checks the
// comparator's c output against a == b. It counts mismatches, with saturation,
// and captures the first failing vector.
// Optional build macro: CMP_BIST_STOP_ON_FAIL_EN ends the run at the first mismatch.
module cmp_bist_sequencer #(
  parameter int WIDTH      = 2,
  parameter int SETTLE_CYC = 1,
  parameter int ERR_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dut_c,
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic             fail_seen
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } state_t;

  // The settle counter only has to reach SETTLE_CYC-1.
  // It keeps one bit even when SETTLE is never entered.
  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE_CYC > 0) ? (SETTLE_CYC - 1) : 0);

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   settle_cnt;

  logic               expect_eq;
  logic               mismatch;
  logic               last_vec;
  logic               launch;
  logic               checking;
  logic               stop_now;
  logic               finish;
  logic               err_sat;
  logic [ERR_W-1:0]   err_next;
  logic [2*WIDTH-1:0] vec_next;

  // Derive the check result, the end-of-run condition and the next operand pair from the current registered state.
  always_comb begin
    expect_eq = (dut_a == dut_b);
    mismatch  = (dut_c != expect_eq);
    last_vec  = (&dut_a) & (&dut_b);
    launch    = ((state_q == IDLE) || (state_q == DONE)) && start;
    checking  = (state_q == CHECK);
`ifdef CMP_BIST_STOP_ON_FAIL_EN
    stop_now  = mismatch;
`else
    stop_now  = 1'b0;
`endif
    finish    = checking && (last_vec || stop_now);
    err_sat   = &err_count;
    err_next  = (mismatch && !err_sat) ? (err_count + ERR_W'(1)) : err_count;
    // b is the low half, so it wraps into a naturally
    vec_next  = {dut_a, dut_b} + (2*WIDTH)'(1);
  end

  // State register; reset abandons any run in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: each vector spends one cycle in DRIVE, SETTLE_CYC cycles in SETTLE and one cycle in CHECK.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (SETTLE_CYC == 0) begin
          state_d = CHECK;
        end else begin
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (finish) begin
          state_d = DONE;
        end else begin
          state_d = DRIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Count the cycles spent in SETTLE; the counter is cleared whenever the FSM is outside SETTLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_cnt <= '0;
    end else if (state_q == SETTLE) begin
      if (settle_cnt == SETTLE_LAST) begin
        settle_cnt <= '0;
      end else begin
        settle_cnt <= settle_cnt + CNT_W'(1);
      end
    end else begin
      settle_cnt <= '0;
    end
  end

  // Registered outputs: set up a run on start, then score and advance on every edge that leaves CHECK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dut_a     <= '0;
      dut_b     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_a    <= '0;
      fail_b    <= '0;
      fail_seen <= 1'b0;
    end else if (launch) begin
      dut_a     <= '0;
      dut_b     <= '0;
      busy      <= 1'b1;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_a    <= '0;
      fail_b    <= '0;
      fail_seen <= 1'b0;
    end else if (checking) begin
      err_count <= err_next;
      if (mismatch && !fail_seen) begin
        fail_a    <= dut_a;
        fail_b    <= dut_b;
        fail_seen <= 1'b1;
      end
      if (finish) begin
        // the last vector, or the failing one when stopping early, stays on the operands
        busy <= 1'b0;
        done <= 1'b1;
        pass <= (err_next == '0);
      end else begin
        {dut_a, dut_b} <= vec_next;
      end
    end
  end

endmodule

// File: tb/tb_cmp_bist_sequencer.sv
// tb_cmp_bist_sequencer: scoreboard bench for cmp_bist_sequencer.
// A behavioural comparator with selectable faults drives dut_c.
// Each start pushes the expected end-of-run result into a queue.
// A monitor checks vector order and hold times, and pops and compares that result when done rises.
`timescale 1ns/1ps
module tb_cmp_bist_sequencer;

  localparam int WIDTH   = 2;
  localparam int SETTLE  = 1;
  localparam int ERR_W   = 5;
  localparam int NVEC    = 16;
  localparam int RUN_LEN = NVEC * (2 + SETTLE);

  typedef struct {
    int err;
    int pass_v;
    int fa;
    int fb;
    int seen;
    int la;
    int lb;
    int done_cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             dut_c;
  logic [WIDTH-1:0] dut_a, dut_b, fail_a, fail_b;
  logic             busy, done, pass, fail_seen;
  logic [ERR_W-1:0] err_count;

  logic             z_start, z_c, z_busy, z_done, z_pass, z_seen;
  logic [WIDTH-1:0] z_a, z_b, z_fa, z_fb;
  logic [2:0]       z_err;

  int   fault_mode;
  int   z_mode;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  // Behavioural comparator: 0 = ideal, 1 = stuck at 0, 2 = stuck at 1, 3 = inverted at a=2, b=2 only
  function automatic logic comparator_model(input int mode, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    case (mode)
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return (a == b) ^ ((a == 2'd2) && (b == 2'd2));
      default: return (a == b);
    endcase
  endfunction

  assign dut_c = comparator_model(fault_mode, dut_a, dut_b);
  assign z_c   = comparator_model(z_mode, z_a, z_b);

  cmp_bist_sequencer #(.WIDTH(WIDTH), .SETTLE_CYC(SETTLE), .ERR_W(ERR_W)) u_dut (
    .clk(clk), .rst(rst), .start(start), .dut_c(dut_c),
    .dut_a(dut_a), .dut_b(dut_b), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_a(fail_a), .fail_b(fail_b), .fail_seen(fail_seen)
  );

  // Zero settle time and a 3-bit error counter, so the counter saturates
  cmp_bist_sequencer #(.WIDTH(WIDTH), .SETTLE_CYC(0), .ERR_W(3)) u_dut_fast (
    .clk(clk), .rst(rst), .start(z_start), .dut_c(z_c),
    .dut_a(z_a), .dut_b(z_b), .busy(z_busy), .done(z_done), .pass(z_pass),
    .err_count(z_err), .fail_a(z_fa), .fail_b(z_fb), .fail_seen(z_seen)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic exp_t make_exp(input int err, input int pass_v, input int fa, input int fb,
                                    input int seen, input int la, input int lb, input int lat);
    exp_t e;
    e.err = err; e.pass_v = pass_v; e.fa = fa; e.fb = fb; e.seen = seen;
    e.la = la; e.lb = lb; e.done_cyc = lat;
    return e;
  endfunction

  // Set the fault mode, pulse start at a negedge and queue the result expected lat edges later
  task automatic applyStimulus(input int mode, input exp_t e);
    @(negedge clk);
    fault_mode = mode;
    start = 1'b1;
    e.done_cyc = cyc + 1 + e.done_cyc;
    sb_q.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 4 * RUN_LEN; i++) begin
      @(negedge clk);
      #1;
      if (sb_q.size() == 0) break;
    end
    checkOutput("scoreboard_drained", sb_q.size(), 0);
    sb_q.delete();
  endtask

  task automatic runFast(input int mode, input int lat, input int err, input int pass_v, input int fa, input int fb);
    int c0;
    @(negedge clk);
    z_mode  = mode;
    z_start = 1'b1;
    c0 = cyc;
    @(posedge clk);
    #1 z_start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (z_done) break;
    end
    checkOutput("fast_latency", cyc - c0 - 1, lat);
    checkOutput("fast_err", int'(z_err), err);
    checkOutput("fast_pass", int'(z_pass), pass_v);
    checkOutput("fast_fail_vec", int'({z_fa, z_fb}), fa * 4 + fb);
    checkOutput("fast_busy", int'(z_busy), 0);
  endtask

  // Monitor: check vector order and hold length during a run, and score each completed run against the queue
  logic [3:0] mon_last = '0;
  logic       mon_busy_prev = 1'b0;
  logic       mon_done_prev = 1'b0;
  int         mon_exp_vec = 0;
  int         mon_hold = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (busy && !mon_busy_prev) begin
        checkOutput("first_vec", int'({dut_a, dut_b}), 0);
        mon_exp_vec = 1;
        mon_hold = 1;
      end else if (busy) begin
        if ({dut_a, dut_b} == mon_last) begin
          mon_hold++;
        end else begin
          checkOutput("hold_len", mon_hold, 2 + SETTLE);
          checkOutput("vec_order", int'({dut_a, dut_b}), mon_exp_vec);
          mon_exp_vec++;
          mon_hold = 1;
        end
      end
      if (done && !mon_done_prev) begin
        checkOutput("last_hold", mon_hold, 2 + SETTLE);
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          checkOutput("done_cycle", cyc, e.done_cyc);
          checkOutput("err_count", int'(err_count), e.err);
          checkOutput("pass", int'(pass), e.pass_v);
          checkOutput("fail_a", int'(fail_a), e.fa);
          checkOutput("fail_b", int'(fail_b), e.fb);
          checkOutput("fail_seen", int'(fail_seen), e.seen);
          checkOutput("final_a", int'(dut_a), e.la);
          checkOutput("final_b", int'(dut_b), e.lb);
          checkOutput("busy_at_done", int'(busy), 0);
        end
      end
    end
    mon_busy_prev = busy;
    mon_done_prev = done;
    mon_last = {dut_a, dut_b};
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    z_start = 1'b0;
    fault_mode = 0;
    z_mode = 0;
    #3;
    checkOutput("reset_outputs",
                int'({dut_a, dut_b, busy, done, pass, err_count, fail_a, fail_b, fail_seen}), 0);
    checkOutput("reset_outputs_fast",
                int'({z_a, z_b, z_busy, z_done, z_pass, z_err, z_fa, z_fb, z_seen}), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Ideal comparator; a start pulse in the middle of the run must be ignored
    applyStimulus(0, make_exp(0, 1, 0, 0, 0, 3, 3, RUN_LEN));
    repeat (10) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitIdle();

`ifdef CMP_BIST_STOP_ON_FAIL_EN
    applyStimulus(1, make_exp(1, 0, 0, 0, 1, 0, 0, 3));
    waitIdle();
`else
    applyStimulus(1, make_exp(4, 0, 0, 0, 1, 3, 3, RUN_LEN));
    waitIdle();
`endif

    // Restart from DONE must clear the previous run's result
    applyStimulus(0, make_exp(0, 1, 0, 0, 0, 3, 3, RUN_LEN));
    checkOutput("restart_err_cleared", int'(err_count), 0);
    checkOutput("restart_done_cleared", int'(done), 0);
    checkOutput("restart_busy", int'(busy), 1);
    checkOutput("restart_seen_cleared", int'(fail_seen), 0);
    waitIdle();

`ifdef CMP_BIST_STOP_ON_FAIL_EN
    applyStimulus(2, make_exp(1, 0, 0, 1, 1, 0, 1, 6));
    waitIdle();
    applyStimulus(3, make_exp(1, 0, 2, 2, 1, 2, 2, 33));
    waitIdle();
`else
    applyStimulus(2, make_exp(12, 0, 0, 1, 1, 3, 3, RUN_LEN));
    waitIdle();
    applyStimulus(3, make_exp(1, 0, 2, 2, 1, 3, 3, RUN_LEN));
    waitIdle();
`endif

    // Asynchronous reset during SETTLE of vector a=1, b=3 (vector 7), then a clean full run
    applyStimulus(0, make_exp(0, 1, 0, 0, 0, 3, 3, RUN_LEN));
    repeat (7 * (2 + SETTLE) + 1) @(posedge clk);
    @(negedge clk);
    checkOutput("pre_reset_vec", int'({dut_a, dut_b}), 7);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_reset_outputs",
                int'({dut_a, dut_b, busy, done, pass, err_count, fail_a, fail_b, fail_seen}), 0);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, make_exp(0, 1, 0, 0, 0, 3, 3, RUN_LEN));
    waitIdle();

    // Zero settle time: 2 cycles per vector; stuck-at-1 saturates the 3-bit counter
    runFast(0, 32, 0, 1, 0, 0);
`ifdef CMP_BIST_STOP_ON_FAIL_EN
    runFast(2, 4, 1, 0, 0, 1);
`else
    runFast(2, 32, 7, 0, 0, 1);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/cmp_bist_sequencer.md
Name: cmp_bist_sequencer

Overview:
- Self-test sequencer for the equality-comparator block (inputs a, b; output c = (a == b)).
- Drives every (a, b) vector pair into the comparator in a fixed order and samples c after a programmable settle time.
- Checks c against the expected equality result, counts mismatches and captures the first failing vector.
- Sits beside the comparator in the FIFO-buffer test harness as the hardware stimulus/checker for the comparator.

Parameters:
- WIDTH, 2, width of each comparator operand; total vectors = 2^(2*WIDTH).
- SETTLE_CYC, 1, wait cycles between applying a vector and sampling c (0 allowed).
- ERR_W, 5, width of the mismatch counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a run; sampled only in IDLE or DONE.
- dut_c  input  1  comparator result under test.
- dut_a  output  WIDTH  operand A driven to the comparator.
- dut_b  output  WIDTH  operand B driven to the comparator.
- busy  output  1  high while a run is in progress.
- done  output  1  run complete; held until the next start or reset.
- pass  output  1  valid when done=1; 1 when err_count == 0.
- err_count  output  ERR_W  number of mismatches; saturates at all-ones.
- fail_a  output  WIDTH  dut_a of the first mismatch.
- fail_b  output  WIDTH  dut_b of the first mismatch.
- fail_seen  output  1  high once fail_a/fail_b hold a captured mismatch.

Behaviour:
- Reset: all outputs 0, state IDLE. Reset is asynchronous and takes effect immediately, including mid-run. No resume: the run is discarded.
- All outputs are registered.
- States: IDLE, DRIVE, SETTLE, CHECK, DONE.
- IDLE or DONE with start=1 at an edge:
  - clear err_count, fail_a, fail_b, fail_seen, done and pass;
  - set dut_a=0, dut_b=0 and busy=1;
  - go to DRIVE.
- start is ignored while busy=1.
- DRIVE: 1 cycle, vector held stable. Go to SETTLE, or to CHECK directly if SETTLE_CYC=0.
- SETTLE: exactly SETTLE_CYC cycles, using an internal counter. Then go to CHECK.
- CHECK: 1 cycle. On the edge leaving CHECK:
  - sample dut_c;
  - mismatch if dut_c != (dut_a == dut_b);
  - on mismatch, err_count increments unless already all-ones;
  - on the first mismatch of the run, load fail_a/fail_b from dut_a/dut_b and set fail_seen.
- Vector order: dut_b is the inner index and dut_a the outer index. On leaving CHECK, dut_b increments; when dut_b wraps from all-ones to 0, dut_a increments.
- End of run: CHECK of vector (all-ones, all-ones) goes to DONE. busy=0, done=1, and pass = (final err_count == 0), including that last check. dut_a/dut_b hold the last vector.
- Latency: done rises exactly 2^(2*WIDTH)*(2+SETTLE_CYC) edges after the edge that sampled start. This is 48 edges for the defaults.
- Each vector occupies 2+SETTLE_CYC cycles.
- A mismatch on the last vector is counted before pass is computed.

Optional Feature:
- Macro: CMP_BIST_STOP_ON_FAIL_EN.
- Defined: the first mismatch moves the sequencer from CHECK directly to DONE.
  - dut_a/dut_b freeze on the failing vector.
  - err_count=1, pass=0, done=1.
- Undefined: all vectors run regardless of mismatches, as described above.

Test Plan:
- Ideal comparator model, defaults, pulse start:
  - dut_a/dut_b step 0/0, 0/1, 0/2, 0/3, 1/0, …, 3/3, each held 3 cycles;
  - done high 48 edges after start, pass=1, err_count=0, fail_seen=0.
- dut_c stuck at 0: err_count=4, pass=0, fail_a=0, fail_b=0, fail_seen=1.
- dut_c stuck at 1: err_count=12, fail_a=0, fail_b=1.
- Assert rst while dut_a=1, dut_b=3, in SETTLE:
  - all outputs 0 immediately, without waiting for a clock edge;
  - a new start then completes a full 48-cycle run with pass=1.
- start pulsed while busy has no effect. In DONE, start=1 restarts and clears err_count.
- SETTLE_CYC=0 with ideal DUT: done after 32 edges.
- With CMP_BIST_STOP_ON_FAIL_EN and a fault only at a=2, b=2: done with dut_a=2, dut_b=2, err_count=1, pass=0.
